// File: rtl/decode_cycle.sv
// ---------------------------------------------------------------------------
// decode_cycle
//
// Instruction-decode stage of a 5-stage RV32I pipeline. It turns the fetched
// instruction into execute-stage control, reads the 32x32 register file, and
// builds the sign-extended immediate. The ID/EX pipeline register is also in
// this block, so every output changes one rising edge after its inputs.
//
// The register file is written from writeback on the same clock. When a
// writeback and a dependent read land on the same edge, the read returns the
// new value (write-before-read bypass).
//
// Optional build macro:
//   DECODE_FLUSH_EN - adds the FlushE input. When FlushE is high it loads a
//                     bubble into the control, immediate and register-index
//                     fields of the ID/EX register. Reset wins over a flush.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous reset, active-low
//   FlushE       in   (DECODE_FLUSH_EN only) squash the ID/EX control fields
//   InstrD       in   32-bit instruction from the IF/ID register
//   PCD          in   PC of InstrD
//   PCPlus4D     in   PC+4 of InstrD
//   RegWriteW    in   writeback register-write enable
//   RDW          in   writeback destination register
//   ResultW      in   writeback data
//   RegWriteE    out  register write enable for the instruction in execute
//   ResultSrcE   out  result select: 00 ALU, 01 memory, 10 PC+4
//   MemWriteE    out  store enable
//   BranchE      out  conditional branch (beq)
//   JumpE        out  jal
//   ALUSrcE      out  ALU operand B select: 0 RD2, 1 immediate
//   ALUControlE  out  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
//   RD1_E        out  rs1 read data
//   RD2_E        out  rs2 read data
//   Imm_Ext_E    out  sign-extended immediate
//   RS1_E        out  InstrD[19:15]
//   RS2_E        out  InstrD[24:20]
//   RD_E         out  InstrD[11:7]
//   PCE          out  registered PCD
//   PCPlus4E     out  registered PCPlus4D
// ---------------------------------------------------------------------------
module decode_cycle #(
  parameter int RF_DEPTH = 32,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
`ifdef DECODE_FLUSH_EN
  input  logic            FlushE,
`endif
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic            ALUSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [XLEN-1:0] Imm_Ext_E,
  output logic [4:0]      RS1_E,
  output logic [4:0]      RS2_E,
  output logic [4:0]      RD_E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  // Supported major opcodes.
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  // ALU operation codes seen by execute.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Which immediate layout the current opcode uses. IMM_NONE produces 0.
  // R-type, jal-less formats and unknown opcodes all use IMM_NONE.
  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J,
    IMM_U
  } immSel_t;

  // Instruction fields.
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_funct7b5;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [4:0] w_rd;

  // Decoded control.
  logic       w_regWrite;
  logic [1:0] w_resultSrc;
  logic       w_memWrite;
  logic       w_branch;
  logic       w_jump;
  logic       w_aluSrc;
  logic [2:0] w_aluCtrl;
  logic [2:0] w_functAlu;
  immSel_t    w_immSel;

  // Immediate candidates and the selected value.
  logic [XLEN-1:0] w_immI;
  logic [XLEN-1:0] w_immS;
  logic [XLEN-1:0] w_immB;
  logic [XLEN-1:0] w_immJ;
  logic [XLEN-1:0] w_immU;
  logic [XLEN-1:0] w_immExt;

  // Register file and its read ports.
  logic [XLEN-1:0] r_regs [RF_DEPTH];
  logic            w_wbValid;
  logic            w_bypass1;
  logic            w_bypass2;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;

  // Bubble request for the ID/EX register.
  logic w_flush;

  // ID/EX pipeline register.
  logic            r_regWriteE;
  logic [1:0]      r_resultSrcE;
  logic            r_memWriteE;
  logic            r_branchE;
  logic            r_jumpE;
  logic            r_aluSrcE;
  logic [2:0]      r_aluCtrlE;
  logic [XLEN-1:0] r_rd1E;
  logic [XLEN-1:0] r_rd2E;
  logic [XLEN-1:0] r_immE;
  logic [4:0]      r_rs1E;
  logic [4:0]      r_rs2E;
  logic [4:0]      r_rdE;
  logic [XLEN-1:0] r_pcE;
  logic [XLEN-1:0] r_pcPlus4E;

  assign w_opcode   = InstrD[6:0];
  assign w_funct3   = InstrD[14:12];
  assign w_funct7b5 = InstrD[30];
  assign w_rs1      = InstrD[19:15];
  assign w_rs2      = InstrD[24:20];
  assign w_rd       = InstrD[11:7];

`ifdef DECODE_FLUSH_EN
  assign w_flush = FlushE;
`else
  assign w_flush = 1'b0;
`endif

  // ALU operation from funct3. funct7[5] only selects subtract for R-type,
  // so an I-type with that bit set still adds (there is no subi).
  always_comb begin
    w_functAlu = ALU_ADD;
    case (w_funct3)
      3'b000: begin
        if ((w_opcode == OP_RTYPE) && w_funct7b5) begin
          w_functAlu = ALU_SUB;
        end
      end
      3'b010:  w_functAlu = ALU_SLT;
      3'b100:  w_functAlu = ALU_XOR;
      3'b110:  w_functAlu = ALU_OR;
      3'b111:  w_functAlu = ALU_AND;
      default: w_functAlu = ALU_ADD;
    endcase
  end

  // Main decoder. Everything defaults to a bubble so an unknown opcode, or
  // an all-zero instruction from a fetch bubble, has no side effects.
  always_comb begin
    w_regWrite  = 1'b0;
    w_resultSrc = 2'b00;
    w_memWrite  = 1'b0;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
    w_aluSrc    = 1'b0;
    w_aluCtrl   = ALU_ADD;
    w_immSel    = IMM_NONE;
    case (w_opcode)
      OP_LOAD: begin
        w_regWrite  = 1'b1;
        w_resultSrc = 2'b01;
        w_aluSrc    = 1'b1;
        w_immSel    = IMM_I;
      end
      OP_STORE: begin
        w_memWrite = 1'b1;
        w_aluSrc   = 1'b1;
        w_immSel   = IMM_S;
      end
      OP_RTYPE: begin
        w_regWrite = 1'b1;
        w_aluCtrl  = w_functAlu;
      end
      OP_IALU: begin
        w_regWrite = 1'b1;
        w_aluSrc   = 1'b1;
        w_aluCtrl  = w_functAlu;
        w_immSel   = IMM_I;
      end
      OP_BEQ: begin
        w_branch  = 1'b1;
        w_aluCtrl = ALU_SUB;
        w_immSel  = IMM_B;
      end
      OP_JAL: begin
        w_regWrite  = 1'b1;
        w_jump      = 1'b1;
        w_resultSrc = 2'b10;
        w_immSel    = IMM_J;
      end
      // Execute forces operand A to zero for lui; here it is just imm + add.
      OP_LUI: begin
        w_regWrite = 1'b1;
        w_aluSrc   = 1'b1;
        w_immSel   = IMM_U;
      end
      default: begin
        w_regWrite = 1'b0;
      end
    endcase
  end

  // All immediate layouts sign-extend from InstrD[31]. B and J have an
  // implicit zero LSB because targets are halfword aligned.
  assign w_immI = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
  assign w_immS = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign w_immB = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                   InstrD[30:25], InstrD[11:8], 1'b0};
  assign w_immJ = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12],
                   InstrD[20], InstrD[30:21], 1'b0};
  assign w_immU = {{(XLEN-32){InstrD[31]}}, InstrD[31:12], 12'b0};

  always_comb begin
    w_immExt = '0;
    case (w_immSel)
      IMM_I:   w_immExt = w_immI;
      IMM_S:   w_immExt = w_immS;
      IMM_B:   w_immExt = w_immB;
      IMM_J:   w_immExt = w_immJ;
      IMM_U:   w_immExt = w_immU;
      default: w_immExt = '0;
    endcase
  end

  // Register file write port. x0 is never written, and reset clears the
  // whole array so reads after reset are deterministic.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wbValid) begin
      r_regs[RDW] <= ResultW;
    end
  end

  // Read ports. The array is only updated on the edge that also captures
  // the read into ID/EX, so a matching writeback is forwarded here to make a
  // same-cycle write and dependent read see the new value.
  assign w_wbValid = RegWriteW && (RDW != 5'd0);
  assign w_bypass1 = w_wbValid && (RDW == w_rs1);
  assign w_bypass2 = w_wbValid && (RDW == w_rs2);

  assign w_rd1 = (w_rs1 == 5'd0) ? '0 :
                 w_bypass1       ? ResultW : r_regs[w_rs1];
  assign w_rd2 = (w_rs2 == 5'd0) ? '0 :
                 w_bypass2       ? ResultW : r_regs[w_rs2];

  // ID/EX pipeline register. Reset clears everything, discarding whatever
  // was in flight. A flush clears control, immediate and register indices
  // so execute sees a harmless bubble (RD_E=0 also defeats any forwarding
  // match); operand data and PCs still load because nothing consumes them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_regWriteE  <= 1'b0;
      r_resultSrcE <= 2'b00;
      r_memWriteE  <= 1'b0;
      r_branchE    <= 1'b0;
      r_jumpE      <= 1'b0;
      r_aluSrcE    <= 1'b0;
      r_aluCtrlE   <= 3'b000;
      r_rd1E       <= '0;
      r_rd2E       <= '0;
      r_immE       <= '0;
      r_rs1E       <= 5'd0;
      r_rs2E       <= 5'd0;
      r_rdE        <= 5'd0;
      r_pcE        <= '0;
      r_pcPlus4E   <= '0;
    end else begin
      r_rd1E     <= w_rd1;
      r_rd2E     <= w_rd2;
      r_pcE      <= PCD;
      r_pcPlus4E <= PCPlus4D;
      if (w_flush) begin
        r_regWriteE  <= 1'b0;
        r_resultSrcE <= 2'b00;
        r_memWriteE  <= 1'b0;
        r_branchE    <= 1'b0;
        r_jumpE      <= 1'b0;
        r_aluSrcE    <= 1'b0;
        r_aluCtrlE   <= 3'b000;
        r_immE       <= '0;
        r_rs1E       <= 5'd0;
        r_rs2E       <= 5'd0;
        r_rdE        <= 5'd0;
      end else begin
        r_regWriteE  <= w_regWrite;
        r_resultSrcE <= w_resultSrc;
        r_memWriteE  <= w_memWrite;
        r_branchE    <= w_branch;
        r_jumpE      <= w_jump;
        r_aluSrcE    <= w_aluSrc;
        r_aluCtrlE   <= w_aluCtrl;
        r_immE       <= w_immExt;
        r_rs1E       <= w_rs1;
        r_rs2E       <= w_rs2;
        r_rdE        <= w_rd;
      end
    end
  end

  assign RegWriteE   = r_regWriteE;
  assign ResultSrcE  = r_resultSrcE;
  assign MemWriteE   = r_memWriteE;
  assign BranchE     = r_branchE;
  assign JumpE       = r_jumpE;
  assign ALUSrcE     = r_aluSrcE;
  assign ALUControlE = r_aluCtrlE;
  assign RD1_E       = r_rd1E;
  assign RD2_E       = r_rd2E;
  assign Imm_Ext_E   = r_immE;
  assign RS1_E       = r_rs1E;
  assign RS2_E       = r_rs2E;
  assign RD_E        = r_rdE;
  assign PCE         = r_pcE;
  assign PCPlus4E    = r_pcPlus4E;

endmodule

// File: tb/tb_decode_cycle.sv
// ---------------------------------------------------------------------------
// tb_decode_cycle
//
// Self-checking bench for decode_cycle. A table of hand-decoded instructions
// with their expected ID/EX contents walks the register file through known
// values, followed by hand-written reset/flush sequences and a randomized
// run compared against an instruction-level reference model.
// ---------------------------------------------------------------------------
module tb_decode_cycle;

  logic        clk;
  logic        rst;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        MemWriteE;
  logic        BranchE;
  logic        JumpE;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic [31:0] Imm_Ext_E;
  logic [4:0]  RS1_E;
  logic [4:0]  RS2_E;
  logic [4:0]  RD_E;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
`ifdef DECODE_FLUSH_EN
  logic        FlushE;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        regWrite;
    logic [1:0]  resultSrc;
    logic        memWrite;
    logic        branch;
    logic        jump;
    logic        aluSrc;
    logic [2:0]  aluCtrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
  } outVec_t;

  typedef struct {
    logic [31:0] instr;
    logic        regWriteW;
    logic [4:0]  rdW;
    logic [31:0] resultW;
    outVec_t     exp;
  } vec_t;

  logic [31:0] mRegs [32];

  decode_cycle dut (
    .clk         (clk),
    .rst         (rst),
`ifdef DECODE_FLUSH_EN
    .FlushE      (FlushE),
`endif
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .RegWriteW   (RegWriteW),
    .RDW         (RDW),
    .ResultW     (ResultW),
    .RegWriteE   (RegWriteE),
    .ResultSrcE  (ResultSrcE),
    .MemWriteE   (MemWriteE),
    .BranchE     (BranchE),
    .JumpE       (JumpE),
    .ALUSrcE     (ALUSrcE),
    .ALUControlE (ALUControlE),
    .RD1_E       (RD1_E),
    .RD2_E       (RD2_E),
    .Imm_Ext_E   (Imm_Ext_E),
    .RS1_E       (RS1_E),
    .RS2_E       (RS2_E),
    .RD_E        (RD_E),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Builds one table row; index fields and PCs are filled in when applied.
  function automatic vec_t mkVec(input logic [31:0] instr, input logic rw,
                                 input logic [4:0] rdw, input logic [31:0] resw,
                                 input logic eRw, input logic [1:0] eRs,
                                 input logic eMw, input logic eBr,
                                 input logic eJ, input logic eAs,
                                 input logic [2:0] eAlu, input logic [31:0] eImm,
                                 input logic [31:0] eRd1, input logic [31:0] eRd2);
    vec_t v;
    v.instr         = instr;
    v.regWriteW     = rw;
    v.rdW           = rdw;
    v.resultW       = resw;
    v.exp.regWrite  = eRw;
    v.exp.resultSrc = eRs;
    v.exp.memWrite  = eMw;
    v.exp.branch    = eBr;
    v.exp.jump      = eJ;
    v.exp.aluSrc    = eAs;
    v.exp.aluCtrl   = eAlu;
    v.exp.imm       = eImm;
    v.exp.rd1       = eRd1;
    v.exp.rd2       = eRd2;
    v.exp.rs1       = 5'd0;
    v.exp.rs2       = 5'd0;
    v.exp.rd        = 5'd0;
    v.exp.pc        = 32'd0;
    v.exp.pcPlus4   = 32'd0;
    return v;
  endfunction

  function automatic outVec_t zeroVec();
    outVec_t e;
    e.regWrite = 1'b0; e.resultSrc = 2'b00; e.memWrite = 1'b0;
    e.branch   = 1'b0; e.jump      = 1'b0;  e.aluSrc   = 1'b0;
    e.aluCtrl  = 3'b000;
    e.rd1 = 32'd0; e.rd2 = 32'd0; e.imm = 32'd0;
    e.rs1 = 5'd0;  e.rs2 = 5'd0;  e.rd  = 5'd0;
    e.pc  = 32'd0; e.pcPlus4 = 32'd0;
    return e;
  endfunction

  // Instruction-level reference: control and immediate from the opcode
  // table, immediates assembled arithmetically from instruction bits.
  function automatic outVec_t refDecode(input logic [31:0] instr);
    outVec_t e;
    int      s;
    int      top;
    logic    isR;
    logic [2:0] aluFromF3;
    e   = zeroVec();
    s   = $signed(instr);
    top = s >>> 31;
    isR = (instr[6:0] == 7'b0110011);
    case (instr[14:12])
      3'd0:    aluFromF3 = (isR && instr[30]) ? 3'd1 : 3'd0;
      3'd2:    aluFromF3 = 3'd5;
      3'd4:    aluFromF3 = 3'd4;
      3'd6:    aluFromF3 = 3'd3;
      3'd7:    aluFromF3 = 3'd2;
      default: aluFromF3 = 3'd0;
    endcase
    case (instr[6:0])
      7'b0000011: begin
        e.regWrite = 1; e.resultSrc = 2'b01; e.aluSrc = 1;
        e.imm = s >>> 20;
      end
      7'b0100011: begin
        e.memWrite = 1; e.aluSrc = 1;
        e.imm = (s >>> 25) * 32 + int'(instr[11:7]);
      end
      7'b0110011: begin
        e.regWrite = 1; e.aluCtrl = aluFromF3;
      end
      7'b0010011: begin
        e.regWrite = 1; e.aluSrc = 1; e.imm = s >>> 20;
        e.aluCtrl = (instr[14:12] == 3'd0) ? 3'd0 : aluFromF3;
      end
      7'b1100011: begin
        e.branch = 1; e.aluCtrl = 3'd1;
        e.imm = top * 4096 + int'(instr[7]) * 2048 + int'(instr[30:25]) * 32
                + int'(instr[11:8]) * 2;
      end
      7'b1101111: begin
        e.regWrite = 1; e.jump = 1; e.resultSrc = 2'b10;
        e.imm = top * 1048576 + int'(instr[19:12]) * 4096
                + int'(instr[20]) * 2048 + int'(instr[30:21]) * 2;
      end
      7'b0110111: begin
        e.regWrite = 1; e.aluSrc = 1; e.imm = instr & 32'hFFFFF000;
      end
      default: e = zeroVec();
    endcase
    return e;
  endfunction

  // One clock of the stage: the writeback lands first, then the operands are
  // read, which is what the same-cycle bypass promises.
  task automatic modelStep(input logic rstN, input logic [31:0] instr,
                           input logic rw, input logic [4:0] rdw,
                           input logic [31:0] resw, input logic [31:0] pc,
                           input logic flush, output outVec_t e);
    logic [4:0] a;
    logic [4:0] b;
    e = zeroVec();
    if (!rstN) begin
      for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
      return;
    end
    if (rw && (rdw != 5'd0)) mRegs[rdw] = resw;
    a = instr[19:15];
    b = instr[24:20];
    e = refDecode(instr);
    e.rd1     = mRegs[a];
    e.rd2     = mRegs[b];
    e.rs1     = a;
    e.rs2     = b;
    e.rd      = instr[11:7];
    e.pc      = pc;
    e.pcPlus4 = pc + 32'd4;
    if (flush) begin
      e.regWrite = 0; e.resultSrc = 0; e.memWrite = 0; e.branch = 0;
      e.jump = 0; e.aluSrc = 0; e.aluCtrl = 0; e.imm = 0;
      e.rs1 = 0; e.rs2 = 0; e.rd = 0;
    end
  endtask

  function automatic logic [31:0] genInstr();
    logic [31:0] w;
    logic [6:0]  op;
    case ($urandom_range(0, 8))
      0:       op = 7'b0000011;
      1:       op = 7'b0100011;
      2:       op = 7'b0110011;
      3:       op = 7'b0010011;
      4:       op = 7'b1100011;
      5:       op = 7'b1101111;
      6:       op = 7'b0110111;
      7:       op = 7'b0110011;
      default: op = 7'($urandom_range(0, 127));
    endcase
    w = $urandom;
    w[6:0] = op;
    if ($urandom_range(0, 15) == 0) w = 32'd0;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input outVec_t e, input string tag);
    chk({tag, ".RegWriteE"},   32'(RegWriteE),   32'(e.regWrite));
    chk({tag, ".ResultSrcE"},  32'(ResultSrcE),  32'(e.resultSrc));
    chk({tag, ".MemWriteE"},   32'(MemWriteE),   32'(e.memWrite));
    chk({tag, ".BranchE"},     32'(BranchE),     32'(e.branch));
    chk({tag, ".JumpE"},       32'(JumpE),       32'(e.jump));
    chk({tag, ".ALUSrcE"},     32'(ALUSrcE),     32'(e.aluSrc));
    chk({tag, ".ALUControlE"}, 32'(ALUControlE), 32'(e.aluCtrl));
    chk({tag, ".RD1_E"},       RD1_E,            e.rd1);
    chk({tag, ".RD2_E"},       RD2_E,            e.rd2);
    chk({tag, ".Imm_Ext_E"},   Imm_Ext_E,        e.imm);
    chk({tag, ".RS1_E"},       32'(RS1_E),       32'(e.rs1));
    chk({tag, ".RS2_E"},       32'(RS2_E),       32'(e.rs2));
    chk({tag, ".RD_E"},        32'(RD_E),        32'(e.rd));
    chk({tag, ".PCE"},         PCE,              e.pc);
    chk({tag, ".PCPlus4E"},    PCPlus4E,         e.pcPlus4);
  endtask

  // Drive one cycle of inputs, clock it in, and settle just past the edge.
  task automatic applyStimulus(input logic rstN, input logic [31:0] instr,
                               input logic rw, input logic [4:0] rdw,
                               input logic [31:0] resw, input logic [31:0] pc,
                               input logic flush);
    rst       = rstN;
    InstrD    = instr;
    RegWriteW = rw;
    RDW       = rdw;
    ResultW   = resw;
    PCD       = pc;
    PCPlus4D  = pc + 32'd4;
`ifdef DECODE_FLUSH_EN
    FlushE    = flush;
`else
    if (flush) $display("[TB] flush requested without DECODE_FLUSH_EN");
`endif
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs[$];
  outVec_t     e;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        rstN;
  logic        rw;
  logic [4:0]  rdw;
  logic [31:0] resw;
  logic        flush;

  initial begin
    // Known register state along the table: x1=10, x3=0xDEADBEEF, x2=7.
    vecs.push_back(mkVec(32'h00500093, 0, 0, 0,            1, 2'b00, 0, 0, 0, 1, 3'd0, 32'd5,        0, 0));
    vecs.push_back(mkVec(32'h00000000, 1, 1, 32'd10,       0, 2'b00, 0, 0, 0, 0, 3'd0, 32'd0,        0, 0));
    vecs.push_back(mkVec(32'h00000000, 1, 3, 32'hDEADBEEF, 0, 2'b00, 0, 0, 0, 0, 3'd0, 32'd0,        0, 0));
    vecs.push_back(mkVec(32'h00018133, 0, 0, 0,            1, 2'b00, 0, 0, 0, 0, 3'd0, 32'd0,        32'hDEADBEEF, 0));
    vecs.push_back(mkVec(32'h40208233, 1, 2, 32'd7,        1, 2'b00, 0, 0, 0, 0, 3'd1, 32'd0,        32'd10, 32'd7));
    vecs.push_back(mkVec(32'h00000033, 1, 0, 32'h1234,     1, 2'b00, 0, 0, 0, 0, 3'd0, 32'd0,        0, 0));
    vecs.push_back(mkVec(32'h00000033, 0, 0, 0,            1, 2'b00, 0, 0, 0, 0, 3'd0, 32'd0,        0, 0));
    vecs.push_back(mkVec(32'hFE532E23, 0, 0, 0,            0, 2'b00, 1, 0, 0, 1, 3'd0, 32'hFFFFFFFC, 0, 0));
    vecs.push_back(mkVec(32'hFE000CE3, 0, 0, 0,            0, 2'b00, 0, 1, 0, 0, 3'd1, 32'hFFFFFFF8, 0, 0));
    vecs.push_back(mkVec(32'h001000EF, 0, 0, 0,            1, 2'b10, 0, 0, 1, 0, 3'd0, 32'h00000800, 0, 32'd10));
    vecs.push_back(mkVec(32'h123452B7, 0, 0, 0,            1, 2'b00, 0, 0, 0, 1, 3'd0, 32'h12345000, 0, 32'hDEADBEEF));
    vecs.push_back(mkVec(32'h40108193, 0, 0, 0,            1, 2'b00, 0, 0, 0, 1, 3'd0, 32'h00000401, 32'd10, 32'd10));
    vecs.push_back(mkVec(32'h0030F2B3, 0, 0, 0,            1, 2'b00, 0, 0, 0, 0, 3'd2, 32'd0,        32'd10, 32'hDEADBEEF));
    vecs.push_back(mkVec(32'hFFF0A313, 0, 0, 0,            1, 2'b00, 0, 0, 0, 1, 3'd5, 32'hFFFFFFFF, 32'd10, 0));
    vecs.push_back(mkVec(32'h001093B3, 0, 0, 0,            1, 2'b00, 0, 0, 0, 0, 3'd0, 32'd0,        32'd10, 32'd10));
    vecs.push_back(mkVec(32'h0030C433, 0, 0, 0,            1, 2'b00, 0, 0, 0, 0, 3'd4, 32'd0,        32'd10, 32'hDEADBEEF));
    vecs.push_back(mkVec(32'h0F00E493, 0, 0, 0,            1, 2'b00, 0, 0, 0, 1, 3'd3, 32'h000000F0, 32'd10, 0));
    vecs.push_back(mkVec(32'h00812283, 0, 0, 0,            1, 2'b01, 0, 0, 0, 1, 3'd0, 32'd8,        32'd7, 0));
    vecs.push_back(mkVec(32'hFFFFFFFF, 0, 0, 0,            0, 2'b00, 0, 0, 0, 0, 3'd0, 32'd0,        0, 0));

    // Reset held for two edges clears every output, including the PCs.
    $display("[TB] reset sequence");
    applyStimulus(0, 32'h00500093, 0, 0, 0, 32'h0000_0040, 0);
    checkOutput(zeroVec(), "reset0");
    applyStimulus(0, 32'h00500093, 0, 0, 0, 32'h0000_0044, 0);
    checkOutput(zeroVec(), "reset1");

    $display("[TB] vector table, %0d rows", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      instr = vecs[i].instr;
      pc    = 32'h100 + 32'(4 * i);
      applyStimulus(1, instr, vecs[i].regWriteW, vecs[i].rdW,
                    vecs[i].resultW, pc, 0);
      e         = vecs[i].exp;
      e.rs1     = instr[19:15];
      e.rs2     = instr[24:20];
      e.rd      = instr[11:7];
      e.pc      = pc;
      e.pcPlus4 = pc + 32'd4;
      checkOutput(e, $sformatf("vec%0d", i));
    end

`ifdef DECODE_FLUSH_EN
    // lw x5,8(x2) squashed: control and indices clear, data/PC still load.
    $display("[TB] flush sequence");
    applyStimulus(1, 32'h00812283, 0, 0, 0, 32'h200, 1);
    e = zeroVec();
    e.rd1 = 32'd7; e.pc = 32'h200; e.pcPlus4 = 32'h204;
    checkOutput(e, "flush");
    applyStimulus(1, 32'h00812283, 0, 0, 0, 32'h204, 0);
    e = zeroVec();
    e.regWrite = 1; e.resultSrc = 2'b01; e.aluSrc = 1; e.imm = 32'd8;
    e.rd1 = 32'd7; e.rs1 = 5'd2; e.rs2 = 5'd8; e.rd = 5'd5;
    e.pc = 32'h204; e.pcPlus4 = 32'h208;
    checkOutput(e, "afterFlush");
    // Reset must win over a simultaneous flush.
    applyStimulus(0, 32'h00812283, 0, 0, 0, 32'h208, 1);
    checkOutput(zeroVec(), "resetOverFlush");
`endif

    // Mid-stream reset with a lw in flight: bubble out, register file wiped.
    $display("[TB] mid-stream reset");
    applyStimulus(0, 32'h00812283, 1, 5'd9, 32'h55, 32'h300, 0);
    checkOutput(zeroVec(), "midReset");
    applyStimulus(1, 32'h00018133, 0, 0, 0, 32'h304, 0);
    e = zeroVec();
    e.regWrite = 1; e.rs1 = 5'd3; e.rd = 5'd2;
    e.pc = 32'h304; e.pcPlus4 = 32'h308;
    checkOutput(e, "afterReset");

    // Randomized run against the reference model, starting from reset.
    $display("[TB] random run");
    applyStimulus(0, 32'd0, 0, 0, 0, 32'd0, 0);
    modelStep(0, 32'd0, 0, 0, 0, 32'd0, 0, e);
    for (int n = 0; n < 500; n++) begin
      rstN  = ($urandom_range(0, 59) != 0);
      instr = genInstr();
      rw    = 1'($urandom_range(0, 1));
      rdw   = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) rdw = instr[19:15];
      resw  = $urandom;
      pc    = $urandom & 32'hFFFFFFFC;
`ifdef DECODE_FLUSH_EN
      flush = ($urandom_range(0, 7) == 0);
`else
      flush = 1'b0;
`endif
      modelStep(rstN, instr, rw, rdw, resw, pc, flush, e);
      applyStimulus(rstN, instr, rw, rdw, resw, pc, flush);
      checkOutput(e, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
Second stage of the 5-stage RV32I pipeline; consumes InstrD, PCD and PCPlus4D from the fetch stage.
- Decodes the instruction into control signals.
- Reads the 32x32 register file, which is written from writeback.
- Sign-extends the immediate.
- Registers all of it into the ID/EX pipeline register that feeds the execute stage.

Parameters:
RF_DEPTH, 32, number of architectural registers (x0 hardwired to zero)
XLEN, 32, datapath width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low
InstrD  input  32  instruction from fetch pipeline register
PCD  input  32  PC of InstrD
PCPlus4D  input  32  PC+4 of InstrD
RegWriteW  input  1  writeback register-write enable
RDW  input  5  writeback destination register
ResultW  input  32  writeback data
RegWriteE  output  1  register write enable to execute
ResultSrcE  output  2  00=ALU, 01=memory, 10=PC+4
MemWriteE  output  1  store enable
BranchE  output  1  conditional branch (beq)
JumpE  output  1  jal
ALUSrcE  output  1  0=RD2, 1=immediate
ALUControlE  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
RD1_E  output  32  rs1 data
RD2_E  output  32  rs2 data
Imm_Ext_E  output  32  sign-extended immediate
RS1_E  output  5  InstrD[19:15]
RS2_E  output  5  InstrD[24:20]
RD_E  output  5  InstrD[11:7]
PCE  output  32  registered PCD
PCPlus4E  output  32  registered PCPlus4D

Behaviour:
- Latency: inputs sampled at edge N appear on all *E outputs after edge N; exactly one register stage. There is no stall input; the stage advances every cycle.
- Reset: while rst==0 at an edge, all *E outputs clear to 0 and all 31 registers x1..x31 clear to 0. Reset asserted mid-stream discards the in-flight instruction, i.e. the first cycle after release shows a bubble (all zero).
- Register file, write:
  - On an edge with RegWriteW==1 and RDW!=0, reg[RDW] <= ResultW.
  - Writes with RDW==0 are ignored; x0 always reads 0.
- Register file, read bypass: on the same edge that a write occurs, the read of rs1/rs2 returns ResultW when RegWriteW==1, RDW!=0 and RDW==rs. This makes a write and a dependent read in the same cycle correct.
- Opcode decode (InstrD[6:0]):
  - 0000011 lw: RegWrite=1, ResultSrc=01, ALUSrc=1, imm I, ALU add.
  - 0100011 sw: MemWrite=1, ALUSrc=1, imm S, ALU add.
  - 0110011 R-type: RegWrite=1, ALUSrc=0, ALU per funct3/funct7.
  - 0010011 I-ALU: RegWrite=1, ALUSrc=1, imm I, ALU per funct3; funct7[5] is ignored, so there is no subi.
  - 1100011 beq: Branch=1, ALUSrc=0, imm B, ALU sub.
  - 1101111 jal: RegWrite=1, Jump=1, ResultSrc=10, imm J.
  - 0110111 lui: RegWrite=1, ALUSrc=1, imm U, ALU add. The operand-A zeroing for lui is done in execute.
- ALU decode (funct3):
  - 000: add, or sub when R-type and funct7[5]==1.
  - 010: slt. 100: xor. 110: or. 111: and.
  - Any other funct3: add.
- Immediate formats, all sign-extended from InstrD[31]:
  - I = Instr[31:20].
  - S = {Instr[31:25], Instr[11:7]}.
  - B = {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}.
  - J = {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}.
  - U = {Instr[31:12], 12'b0}.
- Unknown opcode, including InstrD==0 from a fetch bubble:
  - All control outputs (RegWrite, ResultSrc, MemWrite, Branch, Jump, ALUSrc, ALUControl) are 0.
  - Imm_Ext_E is 0.
  - Data/index fields still register normally.

Optional Feature:
Macro DECODE_FLUSH_EN.
- When defined, the block adds input FlushE (1 bit). FlushE==1 at an edge loads RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE, ALUSrcE, ALUControlE, Imm_Ext_E, RD_E, RS1_E and RS2_E with 0, inserting a bubble. Reset has priority over FlushE.
- When undefined, there is no FlushE port and the pipeline register always loads decoded values.

Test Plan:
- Reset: hold rst=0 for 2 edges with InstrD=0x00500093 -> all *E outputs 0. Release; after the next edge RegWriteE=1, ALUSrcE=1, Imm_Ext_E=5, RD_E=1.
- Write then read: RegWriteW=1, RDW=3, ResultW=0xDEADBEEF for one edge; then InstrD=0x00018133 (add x2,x3,x0) -> RD1_E=0xDEADBEEF, RD2_E=0, ALUControlE=000.
- Bypass: same cycle, InstrD=0x40208233 (sub x4,x1,x2), RegWriteW=1, RDW=2, ResultW=7, with x1=10 -> RD1_E=10, RD2_E=7, ALUControlE=001.
- x0 write: RegWriteW=1, RDW=0, ResultW=0x1234; then read x0 via InstrD=0x00000033 -> RD1_E=0, RD2_E=0.
- Immediates:
  - sw x5,-4(x6) = 0xFE532E23 -> MemWriteE=1, Imm_Ext_E=0xFFFFFFFC.
  - beq x0,x0,-8 = 0xFE000CE3 -> BranchE=1, Imm_Ext_E=0xFFFFFFF8, ALUControlE=001.
  - jal x1,+2048 = 0x001000EF -> JumpE=1, ResultSrcE=10, Imm_Ext_E=0x00000800.
- Bubble/flush:
  - InstrD=0 -> all control outputs 0.
  - With DECODE_FLUSH_EN, a valid lw plus FlushE=1 -> RegWriteE=0, ResultSrcE=00, RD_E=0.
